// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// regfile_sequencer: multi-cycle decode/writeback control for an external
// register file and ALU. Optional RFSEQ_ZERO_R0_EN hardwires R0 to zero.
// Revision: 1.0
// ============================================================================
module regfile_sequencer #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [7:0]        instr_data,
  output logic              instr_ready,
  output logic [1:0]        rf_rd_addr,
  output logic              rf_rs1_addr,
  output logic              rf_rs2_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

  localparam logic [2:0] c_op_nop  = 3'd0;
  localparam logic [2:0] c_op_mov  = 3'd5;
  localparam logic [2:0] c_op_ldi  = 3'd6;
  localparam logic [2:0] c_op_halt = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_IMM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           ir_q, ir_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [2:0]           alu_op_q, alu_op_d;
  logic [DATA_W-1:0]    alu_a_q, alu_a_d;
  logic [DATA_W-1:0]    alu_b_q, alu_b_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;
  logic                 err_q, err_d;
  logic                 unused_reserved;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    wdata_d  = wdata_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          ir_d    = instr_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (ir_q[7:5])
          c_op_nop:  state_d = ST_IDLE;
          c_op_halt: state_d = ST_HALTED;
          c_op_ldi:  state_d = ST_IMM;
          c_op_mov: begin
            wdata_d = rf_rdata1;
            state_d = ST_WB;
          end
          default: begin
            alu_op_d = ir_q[7:5];
            alu_a_d  = rf_rdata1;
            alu_b_d  = rf_rdata2;
            cnt_d    = '0;
            state_d  = ST_EXEC;
          end
        endcase
      end
      ST_IMM: begin
        if (instr_valid) begin
          wdata_d = DATA_W'(instr_data);
          state_d = ST_WB;
        end
      end
      ST_EXEC: begin
        // done wins over the timeout in the final allowed cycle
        if (alu_done) begin
          wdata_d = alu_result;
          cnt_d   = '0;
          state_d = ST_WB;
        end else if (cnt_q == c_cnt_last) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_WB:     state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_IDLE) || (state_d == ST_IMM);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
    start_d  = (state_d == ST_EXEC) && (state_q == ST_DECODE);
`ifdef RFSEQ_ZERO_R0_EN
    we_d     = (state_d == ST_WB) && (ir_q[4:3] != 2'd0);
`else
    we_d     = (state_d == ST_WB);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      wdata_q  <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      wdata_q  <= wdata_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // strobes are masked by rst so a reset landing on WB/EXEC entry never fires them
  assign rf_we       = we_q & ~rst;
  assign alu_start   = start_q & ~rst;
  assign instr_ready = ready_q;
  assign rf_rd_addr  = ir_q[4:3];
  assign rf_rs1_addr = ir_q[2];
  assign rf_rs2_addr = ir_q[1];
  assign rf_wdata    = wdata_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;

  assign unused_reserved = ir_q[0];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// Testbench for regfile_sequencer: directed vector table, reset/halt sequences
// and randomized instructions checked against an architectural register model.
module tb_regfile_sequencer;

`ifdef RFSEQ_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic [1:0] rf_rd_addr;
  logic       rf_rs1_addr;
  logic       rf_rs2_addr;
  logic       rf_we;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata1;
  logic [7:0] rf_rdata2;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_start;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       busy;
  logic       halted;
  logic       err;

  regfile_sequencer #(.DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .rf_rd_addr(rf_rd_addr), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // architectural register file: also serves as the read side seen by the DUT
  logic [7:0] mdl [4];
  assign rf_rdata1 = mdl[{1'b0, rf_rs1_addr}];
  assign rf_rdata2 = mdl[{1'b0, rf_rs2_addr}];

  int total = 0;
  int bad   = 0;
  bit exp_err = 1'b0;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] imm;
    int         dly;
    bit         we;
    logic [1:0] addr;
    logic [7:0] data;
    int         lat;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      default: return 8'h00;
    endcase
  endfunction

  // Drives one instruction and plays the ALU/immediate source; dly is the
  // ALU done delay in EXEC cycles (>=16 never answers) or the LDI byte gap.
  task automatic run_instr(input logic [7:0] ins, input logic [7:0] imm, input int dly,
                           output int we_cnt, output int we_addr, output int we_data,
                           output int lat, output int starts, output int start_t,
                           output int busy_bad);
    bit is_ldi, is_alu, pend, imm_done;
    int gapc;
    is_ldi = (ins[7:5] == 3'd6);
    is_alu = (ins[7:5] >= 3'd1) && (ins[7:5] <= 3'd4);
    pend = 0; imm_done = 0; gapc = 0;
    we_cnt = 0; we_addr = -1; we_data = -1; starts = 0; start_t = -1; busy_bad = 0;
    chk("ready_before_issue", instr_ready, 1);
    instr_valid = 1'b1;
    instr_data  = ins;
    step();
    instr_valid = 1'b0;
    instr_data  = 8'($urandom);
    lat = 1;
    while (lat < 40) begin
      if (rf_we) begin
        we_cnt++;
        we_addr = rf_rd_addr;
        we_data = rf_wdata;
      end
      if (alu_start) begin
        starts++;
        start_t = lat;
      end
      if (pend) begin
        instr_valid = 1'b0;
        pend = 0;
        imm_done = 1;
      end
      if (instr_ready && (!is_ldi || imm_done)) begin
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      alu_done   = 1'b0;
      alu_result = 8'($urandom);
      if (is_alu && start_t >= 0 && lat - start_t == dly) begin
        alu_done   = 1'b1;
        alu_result = alu_fn(alu_op, alu_a, alu_b);
      end else if (!is_alu || lat == 1 || (start_t >= 0 && lat - start_t > dly)) begin
        alu_done = 1'($urandom_range(0, 1));
      end
      if (is_ldi && !imm_done && !pend && instr_ready) begin
        if (gapc == dly) begin
          instr_valid = 1'b1;
          instr_data  = imm;
          pend = 1;
        end else begin
          gapc++;
        end
      end
      step();
      lat++;
    end
    alu_done    = 1'b0;
    instr_valid = 1'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    int wc, wa, wd, lt, st, stt, bb;
    bit is_alu;
    is_alu = (v.ins[7:5] >= 3'd1) && (v.ins[7:5] <= 3'd4);
    if (is_alu && v.dly >= 16) exp_err = 1'b1;
    run_instr(v.ins, v.imm, v.dly, wc, wa, wd, lt, st, stt, bb);
    chk($sformatf("%s ins=%02h we_pulses", tag, v.ins), wc, int'(v.we));
    if (v.we) begin
      chk($sformatf("%s ins=%02h wr_addr", tag, v.ins), wa, int'(v.addr));
      chk($sformatf("%s ins=%02h wr_data", tag, v.ins), wd, int'(v.data));
      mdl[v.addr] = v.data;
    end
    chk($sformatf("%s ins=%02h latency", tag, v.ins), lt, v.lat);
    chk($sformatf("%s ins=%02h alu_starts", tag, v.ins), st, int'(is_alu));
    if (is_alu) chk($sformatf("%s ins=%02h start_cycle", tag, v.ins), stt, 2);
    chk($sformatf("%s ins=%02h busy_profile", tag, v.ins), bb, 0);
    chk($sformatf("%s ins=%02h err", tag, v.ins), err, int'(exp_err));
  endtask

  // expected outcome from the instruction rules and the architectural registers
  function automatic vec_t predict(input logic [7:0] ins, input logic [7:0] imm, input int dly);
    vec_t v;
    logic [2:0] op;
    op = ins[7:5];
    v.ins = ins; v.imm = imm; v.dly = dly;
    v.we = 0; v.addr = ins[4:3]; v.data = 8'h00; v.lat = 2;
    if (op >= 3'd1 && op <= 3'd4) begin
      if (dly < 16) begin
        v.we = 1; v.data = alu_fn(op, mdl[{1'b0, ins[2]}], mdl[{1'b0, ins[1]}]); v.lat = 4 + dly;
      end else begin
        v.lat = 18;
      end
    end else if (op == 3'd5) begin
      v.we = 1; v.data = mdl[{1'b0, ins[2]}]; v.lat = 3;
    end else if (op == 3'd6) begin
      v.we = 1; v.data = imm; v.lat = 4 + dly;
    end
    if (ZERO_R0 && v.addr == 2'd0) v.we = 0;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    chk($sformatf("%s instr_ready", tag), instr_ready, 1);
    chk($sformatf("%s rf_we", tag), rf_we, 0);
    chk($sformatf("%s alu_start", tag), alu_start, 0);
    chk($sformatf("%s busy", tag), busy, 0);
    chk($sformatf("%s halted", tag), halted, 0);
    chk($sformatf("%s err", tag), err, 0);
  endtask

  initial begin
    int viol;
    rst = 1'b1; instr_valid = 1'b0; instr_data = 8'h00;
    alu_done = 1'b0; alu_result = 8'h00;
    mdl[0] = 8'h10; mdl[1] = 8'h22; mdl[2] = 8'h00; mdl[3] = 8'h00;
    step(); step();
    rst = 1'b0;
    check_reset_state("reset");
    chk("reset rf_rd_addr", rf_rd_addr, 0);
    chk("reset alu_a", alu_a, 0);

    tv[0] = '{ins: 8'h3A, imm: 8'h00, dly: 0,  we: 1, addr: 2'd3, data: 8'h32, lat: 4};
    tv[1] = '{ins: 8'hD0, imm: 8'h5A, dly: 0,  we: 1, addr: 2'd2, data: 8'h5A, lat: 4};
    tv[2] = '{ins: 8'hAE, imm: 8'h00, dly: 0,  we: 1, addr: 2'd1, data: 8'h22, lat: 3};
    tv[3] = '{ins: 8'h96, imm: 8'h00, dly: 3,  we: 1, addr: 2'd2, data: 8'h22, lat: 7};
    tv[4] = '{ins: 8'h4A, imm: 8'h00, dly: 15, we: 1, addr: 2'd1, data: 8'hEE, lat: 19};
    tv[5] = '{ins: 8'h58, imm: 8'h00, dly: 99, we: 0, addr: 2'd3, data: 8'h00, lat: 18};
    tv[6] = '{ins: 8'h00, imm: 8'h00, dly: 0,  we: 0, addr: 2'd0, data: 8'h00, lat: 2};
    tv[7] = '{ins: 8'hC0, imm: 8'h77, dly: 2,  we: !ZERO_R0, addr: 2'd0, data: 8'h77, lat: 6};
    for (int i = 0; i < 8; i++) apply("vec", tv[i]);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] ins, imm;
      int dly;
      ins = 8'($urandom);
      ins[7:5] = 3'($urandom_range(0, 6));
      imm = 8'($urandom);
      dly = 0;
      if (ins[7:5] >= 3'd1 && ins[7:5] <= 3'd4) dly = $urandom_range(0, 19);
      if (ins[7:5] == 3'd6) dly = $urandom_range(0, 3);
      apply("rand", predict(ins, imm, dly));
    end

    // reset landing on the alu_start cycle
    instr_valid = 1'b1; instr_data = 8'h3A;
    step();
    instr_valid = 1'b0;
    step();
    chk("pre-rst alu_start", alu_start, 1);
    rst = 1'b1;
    #1;
    chk("rst masks alu_start", alu_start, 0);
    step();
    rst = 1'b0;
    check_reset_state("rst mid-exec");
    exp_err = 1'b0;

    // reset landing on the writeback cycle
    instr_valid = 1'b1; instr_data = 8'hD8;
    step();
    instr_valid = 1'b0;
    step();
    instr_valid = 1'b1; instr_data = 8'hA5;
    step();
    instr_valid = 1'b0;
    chk("pre-rst rf_we", rf_we, 1);
    rst = 1'b1;
    #1;
    chk("rst masks rf_we", rf_we, 0);
    step();
    rst = 1'b0;
    check_reset_state("rst in wb");

    // HALT, then hammer the input for 50 cycles
    instr_valid = 1'b1; instr_data = 8'hE0;
    step();
    instr_data = 8'h3A;
    step();
    chk("halted set", halted, 1);
    viol = 0;
    for (int c = 0; c < 50; c++) begin
      if (instr_ready || !halted || busy || rf_we || alu_start) viol++;
      instr_data = 8'($urandom);
      alu_done = 1'($urandom_range(0, 1));
      step();
    end
    chk("halted hold violations", viol, 0);
    instr_valid = 1'b0; alu_done = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_reset_state("post-halt reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
